// File: rtl/hex_scroll_sequencer.sv
// Scrolls a buffered message of 4-bit display codes right-to-left across NUM_DIGITS HEX positions.
// Optional pause input and PAUSE state are compiled in with `define HEX_SCROLL_PAUSE_EN.
module hex_scroll_sequencer #(
    parameter int TICK_DIV   = 12500000,
    parameter int MSG_DEPTH  = 16,
    parameter int NUM_DIGITS = 6
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    input  logic                    wr_valid,
    input  logic [3:0]              wr_code,
    output logic                    wr_ready,
    input  logic                    clr,
    input  logic                    start,
    input  logic                    stop,
`ifdef HEX_SCROLL_PAUSE_EN
    input  logic                    pause,
`endif
    output logic                    busy,
    output logic                    step,
    output logic [4*NUM_DIGITS-1:0] digit_codes
);

    localparam int CNT_W  = $clog2(MSG_DEPTH + 1);
    localparam int ADDR_W = $clog2(MSG_DEPTH);
    localparam int PTR_W  = $clog2(MSG_DEPTH + NUM_DIGITS);
    localparam int PRE_W  = $clog2(TICK_DIV);
    localparam logic [4*NUM_DIGITS-1:0] ALL_BLANK = {NUM_DIGITS{4'hF}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1
`ifdef HEX_SCROLL_PAUSE_EN
        ,
        PAUSE  = 2'd2
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [PTR_W-1:0]        rdPtr_q, rdPtr_d;
    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic                    step_q, step_d;
    logic [3:0]              buffer [MSG_DEPTH];

    logic                    pauseReq;
    logic                    wrEn;
    logic                    running;
    logic                    tick;
    logic                    lastPtr;
    logic [3:0]              srcCode;

`ifdef HEX_SCROLL_PAUSE_EN
    assign pauseReq = pause;
`else
    assign pauseReq = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            rdPtr_q <= '0;
            presc_q <= '0;
            disp_q  <= ALL_BLANK;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rdPtr_q <= rdPtr_d;
            presc_q <= presc_d;
            disp_q  <= disp_d;
            step_q  <= step_d;
        end
    end

    // Message storage needs no reset: only entries below count_q are ever read.
    always_ff @(posedge CLOCK_50) begin
        if (wrEn) begin
            buffer[count_q[ADDR_W-1:0]] <= wr_code;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !stop && (count_q != '0)) state_d = SCROLL;
            end
            SCROLL: begin
                if (stop)          state_d = IDLE;
`ifdef HEX_SCROLL_PAUSE_EN
                else if (pauseReq) state_d = PAUSE;
            end
            PAUSE: begin
                if (stop)           state_d = IDLE;
                else if (!pauseReq) state_d = SCROLL;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign wrEn    = wr_valid && wr_ready;
    assign tick    = (presc_q == PRE_W'(TICK_DIV - 1));
    assign lastPtr = (rdPtr_q == PTR_W'(count_q) + PTR_W'(NUM_DIGITS - 1));
    assign srcCode = (rdPtr_q < PTR_W'(count_q)) ? buffer[rdPtr_q[ADDR_W-1:0]] : 4'hF;
    // A cycle with pause low counts even while leaving PAUSE, so resume continues seamlessly.
    assign running = (state_q != IDLE) && !stop && !pauseReq;

    always_comb begin
        count_d = count_q;
        rdPtr_d = rdPtr_q;
        presc_d = presc_q;
        disp_d  = disp_q;
        step_d  = 1'b0;
        if (state_q == IDLE) begin
            rdPtr_d = '0;
            presc_d = '0;
            disp_d  = ALL_BLANK;
            if (clr)       count_d = '0;
            else if (wrEn) count_d = count_q + 1'b1;
        end else if (stop) begin
            rdPtr_d = '0;
            presc_d = '0;
            disp_d  = ALL_BLANK;
        end else if (running) begin
            if (tick) begin
                presc_d = '0;
                step_d  = 1'b1;
                disp_d  = {disp_q[4*NUM_DIGITS-5:0], srcCode};
                rdPtr_d = lastPtr ? '0 : rdPtr_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_comb begin
        busy        = (state_q != IDLE);
        wr_ready    = (state_q == IDLE) && (count_q < CNT_W'(MSG_DEPTH)) && !clr;
        step        = step_q;
        digit_codes = disp_q;
    end

endmodule

// File: tb/tb_hex_scroll_sequencer.sv
// Scoreboard bench for hex_scroll_sequencer with a small scroll model (TICK_DIV=4, NUM_DIGITS=6).
// Exercises the pause path too when HEX_SCROLL_PAUSE_EN is defined.
module tb_hex_scroll_sequencer;

    localparam int TD = 4;
    localparam int MD = 16;
    localparam int ND = 6;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b0;
    logic        wr_valid = 1'b0;
    logic [3:0]  wr_code  = 4'h0;
    logic        clr      = 1'b0;
    logic        start    = 1'b0;
    logic        stop     = 1'b0;
`ifdef HEX_SCROLL_PAUSE_EN
    logic        pause    = 1'b0;
`endif
    logic        wr_ready;
    logic        busy;
    logic        step;
    logic [23:0] digit_codes;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [3:0]  msg[$];
    logic [23:0] expQ[$];
    int          modelPtr;
    logic [23:0] modelDisp;

    hex_scroll_sequencer #(.TICK_DIV(TD), .MSG_DEPTH(MD), .NUM_DIGITS(ND)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .wr_valid   (wr_valid),
        .wr_code    (wr_code),
        .wr_ready   (wr_ready),
        .clr        (clr),
        .start      (start),
        .stop       (stop),
`ifdef HEX_SCROLL_PAUSE_EN
        .pause      (pause),
`endif
        .busy       (busy),
        .step       (step),
        .digit_codes(digit_codes)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [23:0] modelNext();
        logic [3:0] src;
        src       = (modelPtr < msg.size()) ? msg[modelPtr] : 4'hF;
        modelDisp = {modelDisp[19:0], src};
        modelPtr  = (modelPtr == msg.size() + ND - 1) ? 0 : modelPtr + 1;
        return modelDisp;
    endfunction

    // Drives one write cycle; accepted codes join the model's message.
    task automatic applyStimulus(input logic [3:0] code, input logic expReady);
        wr_valid = 1'b1;
        wr_code  = code;
        #1;
        checkOutput("wrReady", {31'd0, wr_ready}, {31'd0, expReady});
        if (expReady) msg.push_back(code);
        @(negedge CLOCK_50);
        wr_valid = 1'b0;
    endtask

    task automatic startScroll();
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        checkOutput("busyEntry", {31'd0, busy}, 32'd1);
        checkOutput("dispEntry", {8'd0, digit_codes}, 32'hFFFFFF);
        modelPtr  = 0;
        modelDisp = 24'hFFFFFF;
    endtask

    task automatic waitStep(output int n);
        n = 0;
        do begin
            @(negedge CLOCK_50);
            n++;
        end while (step !== 1'b1 && n < 20);
    endtask

    task automatic runSteps(input int k);
        int n;
        for (int i = 0; i < k; i++) begin
            expQ.push_back(modelNext());
            waitStep(n);
            checkOutput("stepGap", n, TD);
            checkOutput("display", {8'd0, digit_codes}, {8'd0, expQ.pop_front()});
        end
    endtask

    initial begin
        #12;
        checkOutput("rstDisp", {8'd0, digit_codes}, 32'hFFFFFF);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstStep", {31'd0, step}, 32'd0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        #1;
        checkOutput("rstReady", {31'd0, wr_ready}, 32'd1);

        start = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        checkOutput("emptyBusy", {31'd0, busy}, 32'd0);
        checkOutput("emptyDisp", {8'd0, digit_codes}, 32'hFFFFFF);
        start = 1'b0;

        clr      = 1'b1;
        wr_valid = 1'b1;
        wr_code  = 4'h5;
        #1;
        checkOutput("clrReady", {31'd0, wr_ready}, 32'd0);
        @(negedge CLOCK_50);
        clr      = 1'b0;
        wr_valid = 1'b0;
        start    = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        checkOutput("clrBusy", {31'd0, busy}, 32'd0);
        start = 1'b0;

        msg.delete();
        applyStimulus(4'h1, 1'b1);
        applyStimulus(4'h2, 1'b1);
        applyStimulus(4'h3, 1'b1);
        startScroll();
        runSteps(10);
        @(negedge CLOCK_50);
        checkOutput("stepWidth", {31'd0, step}, 32'd0);

        start = 1'b1;
        stop  = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        stop  = 1'b0;
        checkOutput("stopBusy", {31'd0, busy}, 32'd0);
        checkOutput("stopDisp", {8'd0, digit_codes}, 32'hFFFFFF);
        checkOutput("stopStep", {31'd0, step}, 32'd0);

        startScroll();
        runSteps(2);

`ifdef HEX_SCROLL_PAUSE_EN
        begin
            logic [23:0] held;
            int          n;
            repeat (2) @(negedge CLOCK_50);
            pause = 1'b1;
            held  = digit_codes;
            repeat (10) begin
                @(negedge CLOCK_50);
                checkOutput("pauseStep", {31'd0, step}, 32'd0);
                checkOutput("pauseHold", {8'd0, digit_codes}, {8'd0, held});
            end
            pause = 1'b0;
            expQ.push_back(modelNext());
            waitStep(n);
            checkOutput("resumeGap", n, 2);
            checkOutput("resumeDisp", {8'd0, digit_codes}, {8'd0, expQ.pop_front()});
        end
`endif

        @(posedge CLOCK_50);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("asyncDisp", {8'd0, digit_codes}, 32'hFFFFFF);
        checkOutput("asyncBusy", {31'd0, busy}, 32'd0);
        checkOutput("asyncStep", {31'd0, step}, 32'd0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        #1;
        checkOutput("relReady", {31'd0, wr_ready}, 32'd1);
        start = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        checkOutput("relBusy", {31'd0, busy}, 32'd0);
        start = 1'b0;

        msg.delete();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(4'(i + 3), (i < 16));
        end
        startScroll();
        runSteps(MD + ND + 1);
        stop = 1'b1;
        @(negedge CLOCK_50);
        stop = 1'b0;
        checkOutput("finalBusy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/hex_scroll_sequencer.md
Name: hex_scroll_sequencer

Overview:
- Controller that sequences 4-bit display codes onto a bank of NUM_DIGITS seven-segment positions, scrolling a stored message right-to-left at a programmable rate.
- Each output code feeds one instance of the existing 4-bit-to-seven-segment decoder.
- Code map: 0-9 digits; A=L, B=I, C=N, D=F, E=U; F=blank/OFF.
- Sits between the board switch/key glue logic and the HEX decoders.

Parameters:
- TICK_DIV, 12500000, CLOCK_50 cycles per scroll step (4 steps/s at 50 MHz); minimum 2.
- MSG_DEPTH, 16, message buffer entries; power of two.
- NUM_DIGITS, 6, display positions driven (HEX0..HEX5).

Ports:
- CLOCK_50  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- wr_valid  in  1  message write request.
- wr_code  in  4  code to append.
- wr_ready  out  1  buffer accepts a write this cycle.
- clr  in  1  empty the buffer (honoured in IDLE only).
- start  in  1  begin scrolling (level sampled each cycle).
- stop  in  1  end scrolling.
- busy  out  1  high in SCROLL (and PAUSE).
- step  out  1  one-cycle pulse on every display shift.
- digit_codes  out  4*NUM_DIGITS  bits [4k+3:4k] drive HEX k; HEX0 is rightmost.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, count=0, rd_ptr=0, prescaler=0, every digit_codes nibble=4'hF, busy=0, step=0; wr_ready=1 once reset releases.
- wr_ready = (state==IDLE) & (count<MSG_DEPTH) & ~clr, combinational.
- Write accepted when wr_valid & wr_ready: buffer[count]<=wr_code, count+1. Not accepted in SCROLL, when full, or when clr is high.
- clr in IDLE: count<=0 next cycle; display unchanged. clr outside IDLE is ignored.
- States:
  - IDLE -> SCROLL on start & ~stop & count!=0. start with count==0 is ignored.
  - SCROLL -> IDLE on stop. stop wins over start in the same cycle.
- Entering SCROLL: prescaler=0, rd_ptr=0, display all 4'hF, busy=1 the next cycle.
- In SCROLL, prescaler counts 0..TICK_DIV-1. At terminal count, the following happen in the same edge:
  - prescaler wraps to 0 and step pulses for one cycle;
  - display shifts left: HEX k <= HEX k-1 for k>=1, HEX(NUM_DIGITS-1) discarded;
  - HEX0 <= source code.
- First step occurs exactly TICK_DIV cycles after the SCROLL entry edge.
- Source sequence, period count+NUM_DIGITS steps: buffer[0..count-1], then NUM_DIGITS blanks (4'hF), then repeat. rd_ptr counts 0..count+NUM_DIGITS-1 and wraps to 0.
- stop or return to IDLE: display forced all 4'hF, busy=0, step=0, buffer and count retained.
- Reset mid-scroll: immediate return to reset values; buffer contents become don't-care.
- start held high while IDLE re-launches the scroll as soon as the conditions above hold.

Optional Feature:
- Macro HEX_SCROLL_PAUSE_EN.
- Defined:
  - adds input port pause (1 bit) and state PAUSE.
  - SCROLL -> PAUSE when pause=1; PAUSE -> SCROLL when pause=0.
  - In PAUSE: prescaler and rd_ptr frozen, display held, step=0, busy=1.
  - stop from PAUSE -> IDLE with the normal IDLE entry actions; stop has priority over pause.
  - On resume, counting continues from the frozen prescaler value.
- Undefined: no pause port, no PAUSE state; behaviour exactly as above.

Test Plan:
- TICK_DIV=4, NUM_DIGITS=6. Write 1,2,3, then start:
  - cycle 4 after entry: HEX0=1, others F.
  - cycle 8: HEX1=1, HEX0=2.
  - step 9: all F.
  - step 10: HEX0=1 again.
  - step pulses every 4 cycles.
- Full buffer: write 17 codes with wr_valid held -> 16 accepted, wr_ready=0 after the 16th, entry 17 never appears in the scroll.
- start with count=0 -> remains IDLE, busy=0, display all F. Then clr and wr_valid in the same cycle in IDLE -> count stays 0.
- Scrolling, then start=1 and stop=1 in the same cycle -> IDLE next cycle, busy=0, display all F. Restart -> sequence begins again from buffer[0].
- reset_n low mid-scroll, asynchronously between clock edges -> outputs F/0 immediately, without waiting for a clock edge. After release, wr_ready=1 and count=0.
- With HEX_SCROLL_PAUSE_EN:
  - pause=1 for 10 cycles at prescaler=2 -> no step, display frozen.
  - After release, the next step occurs 2 cycles later.
